// File: rtl/video_timing_gen.sv
// Raster timing for the HDMI output path: x/y counters, hsync, vsync, data-enable, line/frame strobes.
// Define TEST_PATTERN_EN to add registered r/g/b eight-bar colour outputs.
module video_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int H_SYNC_POL = 0,
  parameter int V_SYNC_POL = 0,
  parameter int X_W        = 10,
  parameter int Y_W        = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           hsync,
  output logic           vsync,
  output logic           display_on,
  output logic           line_start,
  output logic           frame_start
`ifdef TEST_PATTERN_EN
  ,
  output logic [7:0]     r,
  output logic [7:0]     g,
  output logic [7:0]     b
`endif
);

  localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_ACTIVE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam logic HS_ON  = (H_SYNC_POL != 0);
  localparam logic VS_ON  = (V_SYNC_POL != 0);
  localparam logic [X_W-1:0] X_LAST = X_W'(H_TOTAL - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_TOTAL - 1);

  logic [X_W-1:0] r_x;
  logic [Y_W-1:0] r_y;
  logic           r_hs, r_vs, r_de, r_ls, r_fs;

  logic [X_W-1:0] w_x_nxt;
  logic [Y_W-1:0] w_y_nxt;
  logic           w_x_wrap, w_de_nxt, w_hs_nxt, w_vs_nxt;

  // Outputs are registered from the next counter values so they always describe the current x/y.
  always_comb begin
    w_x_wrap = (r_x == X_LAST);
    w_x_nxt  = w_x_wrap ? '0 : r_x + X_W'(1);
    w_y_nxt  = r_y;
    if (w_x_wrap) begin
      w_y_nxt = (r_y == Y_LAST) ? '0 : r_y + Y_W'(1);
    end
    w_de_nxt = (int'(w_x_nxt) < H_ACTIVE) && (int'(w_y_nxt) < V_ACTIVE);
    w_hs_nxt = ((int'(w_x_nxt) >= HS_START) && (int'(w_x_nxt) < HS_END)) ? HS_ON : ~HS_ON;
    w_vs_nxt = ((int'(w_y_nxt) >= VS_START) && (int'(w_y_nxt) < VS_END)) ? VS_ON : ~VS_ON;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x  <= X_LAST;
      r_y  <= Y_LAST;
      r_hs <= ~HS_ON;
      r_vs <= ~VS_ON;
      r_de <= 1'b0;
      r_ls <= 1'b0;
      r_fs <= 1'b0;
    end else if (en) begin
      r_x  <= w_x_nxt;
      r_y  <= w_y_nxt;
      r_hs <= w_hs_nxt;
      r_vs <= w_vs_nxt;
      r_de <= w_de_nxt;
      r_ls <= w_x_wrap;
      r_fs <= w_x_wrap && (w_y_nxt == '0);
    end else begin
      r_ls <= 1'b0;
      r_fs <= 1'b0;
    end
  end

  assign x           = r_x;
  assign y           = r_y;
  assign hsync       = r_hs;
  assign vsync       = r_vs;
  assign display_on  = r_de;
  assign line_start  = r_ls;
  assign frame_start = r_fs;

`ifdef TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;
  localparam logic [X_W-1:0] BAR_LAST = X_W'(BAR_W - 1);

  // Bar index bits map straight onto the colour: idx 0..7 = W Y C G M R B K.
  function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
    return {{8{~idx[1]}}, {8{~idx[2]}}, {8{~idx[0]}}};
  endfunction

  logic [X_W-1:0] r_bar_cnt, w_bar_cnt_nxt;
  logic [2:0]     r_bar_idx, w_bar_idx_nxt;
  logic [23:0]    r_rgb;

  always_comb begin
    w_bar_cnt_nxt = r_bar_cnt - X_W'(1);
    w_bar_idx_nxt = r_bar_idx;
    if (w_x_wrap) begin
      w_bar_cnt_nxt = BAR_LAST;
      w_bar_idx_nxt = '0;
    end else if (r_bar_cnt == '0) begin
      w_bar_cnt_nxt = BAR_LAST;
      w_bar_idx_nxt = r_bar_idx + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bar_cnt <= '0;
      r_bar_idx <= '0;
      r_rgb     <= '0;
    end else if (en) begin
      r_bar_cnt <= w_bar_cnt_nxt;
      r_bar_idx <= w_bar_idx_nxt;
      r_rgb     <= w_de_nxt ? bar_rgb(w_bar_idx_nxt) : 24'h000000;
    end
  end

  assign r = r_rgb[23:16];
  assign g = r_rgb[15:8];
  assign b = r_rgb[7:0];
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: a default-timing instance plus a small positive-polarity instance for whole-frame checks.
module tb_video_timing_gen;
  localparam int SHA = 16, SHF = 2, SHS = 4, SHB = 2, SHT = 24;
  localparam int SVA = 6,  SVF = 1, SVS = 2, SVB = 1, SVT = 10;

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic [9:0] x, y;
  logic hs, vs, de, ls, fs;
  logic [4:0] sx;
  logic [3:0] sy;
  logic shs, svs, sde, sls, sfs;
`ifdef TEST_PATTERN_EN
  logic [7:0] r, g, b, sr, sg, sb;
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  int rgb_bad = 0;
`endif

  int n_vec = 0, n_err = 0;
  int cyc = 0, mx, my, s_bad = 0, wide = 0, vs_edge_bad = 0;
  int fs_last = -1, fs_per = 0, vs_cnt = 0, de_cnt = 0;
  int d_hs_low = 0, d_hs_first = -1, d_hs_last = -1, d_de = 0;
  int d_ls_last = -1, d_ls_per = 0;
  logic p_sls = 0, p_sfs = 0, p_ls = 0, p_fs = 0, p_svs = 0;
  bit found;

  always #5 clk = ~clk;

  video_timing_gen dut (
    .clk(clk), .rst_n(rst_n), .en(en), .x(x), .y(y), .hsync(hs), .vsync(vs),
    .display_on(de), .line_start(ls), .frame_start(fs)
`ifdef TEST_PATTERN_EN
    , .r(r), .g(g), .b(b)
`endif
  );

  video_timing_gen #(
    .H_ACTIVE(SHA), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_ACTIVE(SVA), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
    .H_SYNC_POL(1), .V_SYNC_POL(1), .X_W(5), .Y_W(4)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .en(en), .x(sx), .y(sy), .hsync(shs), .vsync(svs),
    .display_on(sde), .line_start(sls), .frame_start(sfs)
`ifdef TEST_PATTERN_EN
    , .r(sr), .g(sg), .b(sb)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic en_at;
    @(posedge clk);
    en_at = en;
    if (en_at && rst_n) begin
      if (mx == SHT - 1) begin
        mx = 0;
        my = (my == SVT - 1) ? 0 : my + 1;
      end else begin
        mx++;
      end
    end
    @(negedge clk);
    cyc++;
    if (sx !== 5'(mx) || sy !== 4'(my)) s_bad++;
    if (sde !== (mx < SHA && my < SVA)) s_bad++;
    if (shs !== (mx >= SHA + SHF && mx < SHA + SHF + SHS)) s_bad++;
    if (svs !== (my >= SVA + SVF && my < SVA + SVF + SVS)) s_bad++;
    if (sls !== (en_at && mx == 0)) s_bad++;
    if (sfs !== (en_at && mx == 0 && my == 0)) s_bad++;
    if ((p_sls && sls) || (p_sfs && sfs) || (p_ls && ls) || (p_fs && fs)) wide++;
    if (svs !== p_svs && sx != 5'd0) vs_edge_bad++;
    p_sls = sls; p_sfs = sfs; p_ls = ls; p_fs = fs; p_svs = svs;
    if (sfs === 1'b1) begin
      if (fs_last >= 0) fs_per = cyc - fs_last;
      fs_last = cyc;
    end
    if (svs === 1'b1) vs_cnt++;
    if (sde === 1'b1) de_cnt++;
    if (hs === 1'b0) begin
      d_hs_low++;
      if (d_hs_first < 0) d_hs_first = int'(x);
      d_hs_last = int'(x);
    end
    if (de === 1'b1) d_de++;
    if (ls === 1'b1) begin
      if (d_ls_last >= 0) d_ls_per = cyc - d_ls_last;
      d_ls_last = cyc;
    end
`ifdef TEST_PATTERN_EN
    if ({sr, sg, sb} !== ((mx < SHA && my < SVA) ? bars[mx / 2] : 24'h000000)) rgb_bad++;
    if (y == 10'd0) begin
      case (x)
        10'd0:   chk("rgb_x0",   {r, g, b}, 24'hFFFFFF);
        10'd79:  chk("rgb_x79",  {r, g, b}, 24'hFFFFFF);
        10'd80:  chk("rgb_x80",  {r, g, b}, 24'hFFFF00);
        10'd400: chk("rgb_x400", {r, g, b}, 24'hFF0000);
        10'd639: chk("rgb_x639", {r, g, b}, 24'h000000);
        10'd640: chk("rgb_x640", {r, g, b}, 24'h000000);
        default: ;
      endcase
    end
`endif
  endtask

  initial begin
    #23;
    chk("rst_x", x, 799);       chk("rst_y", y, 524);
    chk("rst_hs", hs, 1);       chk("rst_vs", vs, 1);
    chk("rst_de", de, 0);       chk("rst_ls", ls, 0);
    chk("rst_fs", fs, 0);
    chk("rst_sx", sx, SHT - 1); chk("rst_sy", sy, SVT - 1);
    chk("rst_shs", shs, 0);     chk("rst_svs", svs, 0);
    chk("rst_sde", sde, 0);     chk("rst_sls", sls, 0);
    chk("rst_sfs", sfs, 0);
`ifdef TEST_PATTERN_EN
    chk("rst_rgb", {r, g, b}, 24'h000000);
`endif

    // first enabled edge after release
    @(negedge clk);
    mx = SHT - 1; my = SVT - 1;
    rst_n = 1'b1; en = 1'b1;
    step();
    chk("first_x", x, 0);   chk("first_y", y, 0);
    chk("first_de", de, 1); chk("first_ls", ls, 1);
    chk("first_fs", fs, 1); chk("first_hs", hs, 1);
    chk("first_vs", vs, 1);
    chk("first_sfs", sfs, 1); chk("first_shs", shs, 0); chk("first_svs", svs, 0);

    // one full default line
    d_hs_low = 0; d_hs_first = -1; d_hs_last = -1; d_de = 0;
    repeat (800) step();
    chk("line_hs_len", d_hs_low, 96);
    chk("line_hs_first", d_hs_first, 656);
    chk("line_hs_last", d_hs_last, 751);
    chk("line_de_len", d_de, 640);
    chk("line_ls_period", d_ls_per, 800);

    // two whole small frames
    s_bad = 0; wide = 0; vs_edge_bad = 0; fs_last = -1; fs_per = 0; vs_cnt = 0; de_cnt = 0;
    repeat (2 * SHT * SVT) step();
    chk("frame_model", s_bad, 0);
    chk("frame_vs_len", vs_cnt, 2 * SVS * SHT);
    chk("frame_de_len", de_cnt, 2 * SHA * SVA);
    chk("frame_fs_period", fs_per, SHT * SVT);
    chk("frame_wide_strobe", wide, 0);
    chk("frame_vs_edge", vs_edge_bad, 0);

    // en toggling every cycle
    s_bad = 0; wide = 0; fs_last = -1; fs_per = 0; d_ls_last = -1; d_ls_per = 0;
    for (int i = 0; i < 3200; i++) begin
      en = ~en;
      step();
    end
    en = 1'b1;
    chk("toggle_model", s_bad, 0);
    chk("toggle_fs_period", fs_per, 2 * SHT * SVT);
    chk("toggle_ls_period", d_ls_per, 1600);
    chk("toggle_wide_strobe", wide, 0);

    // asynchronous reset mid-clock
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (x == 10'd300) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk("arst_reach_x300", found, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_x", x, 799);      chk("arst_y", y, 524);
    chk("arst_hs", hs, 1);      chk("arst_vs", vs, 1);
    chk("arst_de", de, 0);
    chk("arst_sx", sx, SHT - 1); chk("arst_sy", sy, SVT - 1);
    chk("arst_shs", shs, 0);    chk("arst_svs", svs, 0);
    chk("arst_sde", sde, 0);    chk("arst_sls", sls, 0);
    chk("arst_sfs", sfs, 0);
    @(negedge clk);
    @(negedge clk);
    mx = SHT - 1; my = SVT - 1;
    rst_n = 1'b1;
    step();
    chk("rel_x", x, 0);   chk("rel_y", y, 0);   chk("rel_fs", fs, 1);
    chk("rel_sx", sx, 0); chk("rel_sy", sy, 0); chk("rel_sfs", sfs, 1);

    s_bad = 0;
    repeat (SHT * SVT + 20) step();
    chk("final_model", s_bad, 0);
`ifdef TEST_PATTERN_EN
    chk("small_rgb", rgb_bad, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Generates raster timing for the HDMI output path: horizontal and vertical counters, hsync, vsync, data-enable, and line/frame strobes.
- Sits directly upstream of the per-channel TMDS encoders.
- display_on drives each encoder's video-data-enable input; {vsync, hsync} drives the blue channel's 2-bit control-data input; x/y feed the pixel generator.
- Runs in the pixel clock domain; an optional clock-enable supports pixel-rate division.

Parameters:
- H_ACTIVE, 640, visible pixels per line (multiple of 8)
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, vertical back porch (lines)
- H_SYNC_POL, 0, hsync level while asserted (0 = active-low)
- V_SYNC_POL, 0, vsync level while asserted
- X_W, 10, x counter width; H_TOTAL-1 < 2**X_W required
- Y_W, 10, y counter width; V_TOTAL-1 < 2**Y_W required

Ports:
- clk, input, 1, pixel clock
- rst_n, input, 1, asynchronous active-low reset
- en, input, 1, pixel advance enable
- x, output, X_W, horizontal count h (0..H_TOTAL-1)
- y, output, Y_W, vertical count v (0..V_TOTAL-1)
- hsync, output, 1, horizontal sync at configured polarity
- vsync, output, 1, vertical sync at configured polarity
- display_on, output, 1, 1 inside the active area
- line_start, output, 1, one-cycle strobe when x becomes 0
- frame_start, output, 1, one-cycle strobe when x=0 and y=0

Behaviour:
- H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (default 800). V_TOTAL likewise (default 525).
- All outputs are flops, computed from next-state counter values, so they always describe the current x/y. No extra latency.
- Reset (rst_n low, asynchronous, no clock needed):
  - x=H_TOTAL-1, y=V_TOTAL-1
  - display_on=0, line_start=0, frame_start=0
  - hsync=~H_SYNC_POL, vsync=~V_SYNC_POL
- Reset release is synchronous to clk. The first enabled edge yields x=0, y=0.
- On each edge with en=1:
  - x increments; at H_TOTAL-1 it wraps to 0.
  - y increments only on the x wrap; at V_TOTAL-1 (and x wrap) it wraps to 0.
- en=0: x, y, hsync, vsync, display_on hold. line_start and frame_start are driven 0.
- A strobe is a single cycle even if en drops the next cycle.
- display_on = (x < H_ACTIVE) && (y < V_ACTIVE).
- hsync asserted for H_ACTIVE+H_FRONT <= x < H_ACTIVE+H_FRONT+H_SYNC, on every line including vertical blanking.
- vsync asserted for V_ACTIVE+V_FRONT <= y < V_ACTIVE+V_FRONT+V_SYNC. It changes only when x becomes 0 (whole lines).
- line_start=1 on the cycle x becomes 0. frame_start=1 on the cycle x and y both become 0. Both strobes are high together at a frame boundary.
- Counter compares use full X_W/Y_W widths with no truncation. Out-of-range parameters are a configuration error and are not checked at runtime.

Optional Feature:
- Macro TEST_PATTERN_EN.
- Defined: adds output ports r, g, b (8 bits each), registered with the same timing as display_on.
  - Eight vertical colour bars, each H_ACTIVE/8 pixels wide, in order: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
  - Bar index comes from a bar-width down-counter reloaded at line_start. No divider.
  - rgb = 000000 whenever display_on=0.
  - Holds with en=0. Reset value 000000.
- Undefined: r/g/b ports and bar logic are absent. The rest of the block is identical.

Test Plan:
- Reset, then en=1 constant, default params -> first edge after release: x=0, y=0, display_on=1, line_start=1, frame_start=1, hsync=1, vsync=1.
- Run one line -> hsync=0 exactly for x=656..751 (96 cycles); display_on low from x=640; line_start period 800 cycles.
- Run full frames -> vsync=0 for y=490..491 (1600 cycles, edges at x=0); frame_start period 420000 cycles; display_on high 307200 cycles per frame.
- en toggling 1/0 each cycle -> frame_start period 840000 cycles; outputs hold during en=0; strobes never wider than one cycle.
- Assert rst_n low asynchronously at x=300, y=100 (mid-clock) -> outputs go to reset values before the next edge. After release, the first enabled edge gives x=0, y=0, frame_start=1.
- TEST_PATTERN_EN defined, y=0:
  - x=0 -> FFFFFF; x=79 -> FFFFFF; x=80 -> FFFF00
  - x=400 -> FF0000; x=639 -> 000000; x=640 -> 000000
  - y=480 -> 000000 for all x
